// File: rtl/comparador_serial_ctrl_if.sv
// Request/result bundle between a requesting FSM (master) and the serial
// comparator controller (slave).
interface comparador_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             maior;
    logic             menor;
    logic             igual;

    modport master (
        output start, a, b,
        input  busy, done, maior, menor, igual
    );

    modport slave (
        input  start, a, b,
        output busy, done, maior, menor, igual
    );
endinterface

// File: rtl/comparador_serial_ctrl.sv
// Serial MSB-first magnitude comparator built around one shared 1-bit comparator.
// Define COMPARADOR_SIGNED_EN to compare the operands as two's complement.

module comparador1bit_struct (
    input  logic a,
    input  logic b,
    output logic maior,
    output logic menor,
    output logic igual
);
    logic a_n;
    logic b_n;

    not  g_na (a_n, a);
    not  g_nb (b_n, b);
    and  g_gt (maior, a, b_n);
    and  g_lt (menor, a_n, b);
    xnor g_eq (igual, a, b);
endmodule

module comparador_serial_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    comparador_serial_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] index;

    logic res_maior;
    logic res_menor;
    logic res_igual;

    logic busy_q;
    logic done_q;
    logic maior_q;
    logic menor_q;
    logic igual_q;

    logic bit_maior;
    logic bit_menor;
    logic bit_igual;
    logic sign_bit;
    logic eff_maior;
    logic eff_menor;
    logic differ;
    logic last_bit;

    logic accept;
    logic shift_en;
    logic latch_result;
    logic load_outputs;
    logic busy_d;
    logic done_d;

    comparador1bit_struct u_cmp (
        .a     (a_sh[WIDTH-1]),
        .b     (b_sh[WIDTH-1]),
        .maior (bit_maior),
        .menor (bit_menor),
        .igual (bit_igual)
    );

    // In signed mode only the sign bit flips the meaning of the 1-bit result.
`ifdef COMPARADOR_SIGNED_EN
    assign sign_bit = (index == CNT_W'(WIDTH - 1));
`else
    assign sign_bit = 1'b0;
`endif

    assign eff_maior = sign_bit ? bit_menor : bit_maior;
    assign eff_menor = sign_bit ? bit_maior : bit_menor;
    assign differ    = ~bit_igual;
    assign last_bit  = (index == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (differ || last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        accept       = 1'b0;
        shift_en     = 1'b0;
        latch_result = 1'b0;
        load_outputs = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.start;
            end
            COMPARE: begin
                busy_d       = 1'b1;
                latch_result = differ || last_bit;
                shift_en     = !(differ || last_bit);
            end
            DONE: begin
                done_d       = 1'b1;
                load_outputs = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Handshake and result outputs trail the state by one edge, so the
    // results only become visible together with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            index     <= '0;
            res_maior <= 1'b0;
            res_menor <= 1'b0;
            res_igual <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            maior_q   <= 1'b0;
            menor_q   <= 1'b0;
            igual_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (accept) begin
                a_sh      <= bus.a;
                b_sh      <= bus.b;
                index     <= CNT_W'(WIDTH - 1);
                res_maior <= 1'b0;
                res_menor <= 1'b0;
                res_igual <= 1'b0;
                maior_q   <= 1'b0;
                menor_q   <= 1'b0;
                igual_q   <= 1'b0;
            end else if (shift_en) begin
                a_sh  <= a_sh << 1;
                b_sh  <= b_sh << 1;
                index <= index - CNT_W'(1);
            end
            if (latch_result) begin
                res_maior <= eff_maior;
                res_menor <= eff_menor;
                res_igual <= ~differ;
            end
            if (load_outputs) begin
                maior_q <= res_maior;
                menor_q <= res_menor;
                igual_q <= res_igual;
            end
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.maior = maior_q;
    assign bus.menor = menor_q;
    assign bus.igual = igual_q;
endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Scoreboard bench for comparador_serial_ctrl: random and directed operand
// pairs checked against an arithmetic reference model (honours COMPARADOR_SIGNED_EN).
module tb_comparador_serial_ctrl;
    localparam int W = 8;

    typedef struct {
        logic [2:0]   res;
        int           start_edge;
        int           lat;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    comparador_serial_ctrl_if #(.WIDTH(W)) bus ();

    comparador_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Result and latency derived from plain arithmetic on the operands.
    function automatic void refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [2:0] res, output int lat);
        logic [W-1:0] diff;
`ifdef COMPARADOR_SIGNED_EN
        if ($signed(x) > $signed(y))      res = 3'b100;
        else if ($signed(x) < $signed(y)) res = 3'b010;
        else                              res = 3'b001;
`else
        if (x > y)      res = 3'b100;
        else if (x < y) res = 3'b010;
        else            res = 3'b001;
`endif
        diff = x ^ y;
        lat  = W + 1;
        for (int i = 0; i < W; i++) begin
            if (diff[i]) lat = W - i + 1;
        end
    endfunction

    task automatic genPair(output logic [W-1:0] x, output logic [W-1:0] y);
        x = W'($urandom);
        case ($urandom_range(0, 3))
            0: y = x;
            1: y = x ^ (W'(1) << $urandom_range(0, W - 1));
            default: y = W'($urandom);
        endcase
    endtask

    task automatic checkOutput(input logic [2:0] exp_res, input string name);
        checks++;
        if ({bus.maior, bus.menor, bus.igual} !== exp_res || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s: got mmi=%b busy=%b done=%b, want mmi=%b busy=0 done=0",
                     name, {bus.maior, bus.menor, bus.igual}, bus.busy, bus.done, exp_res);
        end
    endtask

    task automatic pushExpected(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [2:0] res, output int lat, output int s);
        exp_t e;
        refModel(x, y, res, lat);
        s = cyc + 1;
        e.res = res; e.lat = lat; e.start_edge = s; e.ea = x; e.eb = y;
        sb.push_back(e);
    endtask

    // One pulsed request; operands scrambled after acceptance, optional
    // stray start while busy, then results held for a few idle cycles.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit spurious, input int gap);
        logic [2:0] res;
        int         lat;
        int         s;
        int         waited;
        @(negedge clk);
        bus.a = x; bus.b = y; bus.start = 1'b1;
        pushExpected(x, y, res, lat, s);
        @(negedge clk);
        bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
        if (spurious) begin
            @(negedge clk);
            bus.start = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom);
            @(negedge clk);
            bus.start = 1'b0;
        end
        waited = 0;
        while (!bus.done && waited < 4 * W) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, want done for a=%h b=%h", waited, x, y);
        end
        repeat (gap) begin
            @(negedge clk);
            checkOutput(res, "result_hold");
        end
    endtask

    task automatic runBackToBack(input int n);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [2:0]   res;
        int           lat;
        int           s;
        @(negedge clk);
        genPair(x, y);
        bus.a = x; bus.b = y; bus.start = 1'b1;
        pushExpected(x, y, res, lat, s);
        for (int i = 0; i < n; i++) begin
            while (cyc < s + lat) @(negedge clk);
            if (i == n - 1) begin
                bus.start = 1'b0;
            end else begin
                genPair(x, y);
                bus.a = x; bus.b = y;
                pushExpected(x, y, res, lat, s);
            end
        end
        @(negedge clk);
        checkOutput(res, "b2b_hold");
    endtask

    task automatic resetMidOp();
        @(negedge clk);
        bus.a = W'(1); bus.b = '0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput(3'b000, "reset_mid_immediate");
        @(negedge clk);
        checkOutput(3'b000, "reset_mid_held");
        rst_n = 1'b1;
        repeat (W + 3) begin
            @(negedge clk);
            checkOutput(3'b000, "after_reset_no_done");
        end
    endtask

    // Monitor: pops one expectation per done and checks result, latency and busy length.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (bus.busy) begin
                    busy_cnt++;
                    checks++;
                    if ({bus.maior, bus.menor, bus.igual} !== 3'b000 || bus.done !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL busy_outputs: got mmi=%b done=%b, want mmi=000 done=0",
                                 {bus.maior, bus.menor, bus.igual}, bus.done);
                    end
                end
                if (bus.done) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, want no pending request", cyc);
                    end else begin
                        e = sb.pop_front();
                        if ({bus.maior, bus.menor, bus.igual} !== e.res) begin
                            errors++;
                            $display("[TB] FAIL result a=%h b=%h: got mmi=%b, want mmi=%b",
                                     e.ea, e.eb, {bus.maior, bus.menor, bus.igual}, e.res);
                        end
                        checks++;
                        if (cyc - e.start_edge != e.lat) begin
                            errors++;
                            $display("[TB] FAIL latency a=%h b=%h: got %0d edges, want %0d",
                                     e.ea, e.eb, cyc - e.start_edge, e.lat);
                        end
                        checks++;
                        if (busy_cnt != e.lat - 1) begin
                            errors++;
                            $display("[TB] FAIL busy_length a=%h b=%h: got %0d cycles, want %0d",
                                     e.ea, e.eb, busy_cnt, e.lat - 1);
                        end
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test by time %0t, want completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.a = 8'h3C;
        bus.b = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            checkOutput(3'b000, "reset_state");
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput(3'b000, "post_reset_idle");

        applyStimulus(8'h80, 8'h7F, 1'b0, 2);
        applyStimulus(8'h10, 8'h11, 1'b0, 2);
        applyStimulus(8'hA5, 8'hA5, 1'b0, 5);
        applyStimulus(8'h01, 8'h00, 1'b1, 2);
        applyStimulus(8'hFF, 8'h01, 1'b0, 2);
        applyStimulus(8'h00, 8'hFF, 1'b0, 1);
        applyStimulus(8'h7F, 8'h80, 1'b1, 1);

        for (int i = 0; i < 40; i++) begin
            genPair(x, y);
            applyStimulus(x, y, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
        end

        runBackToBack(12);
        resetMidOp();
        applyStimulus(8'hC3, 8'hC2, 1'b0, 2);

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_requests: got %0d unanswered, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/comparador_serial_ctrl.md
Name: comparador_serial_ctrl

Overview:
- Sequential controller that compares two WIDTH-bit operands serially, MSB first.
- Drives one instance of the team's 1-bit structural comparator (comparador1bit_struct) with one bit pair per clock.
- Terminates early on the first differing bit.
- Used where a single shared 1-bit comparator replaces a wide parallel magnitude comparator; start/busy/done handshake toward the requesting FSM.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-index counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while in COMPARE.
- done  output  1  one-cycle pulse; results valid from this cycle.
- maior  output  1  result a > b.
- menor  output  1  result a < b.
- igual  output  1  result a == b.

Behaviour:
- Interface: single clock clk. Reset rst_n is asynchronous, active-low. All state and outputs are registered.
- Reset values: state=IDLE, busy=0, done=0, maior=0, menor=0, igual=0, shift regs=0, index=0.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - start=1 at an edge: load a_sh<=a, b_sh<=b, index<=WIDTH-1; clear maior/menor/igual to 0; go COMPARE.
  - start=0: stay in IDLE.
- COMPARE:
  - busy=1.
  - The 1-bit comparator inputs are a_sh[WIDTH-1] and b_sh[WIDTH-1].
  - At each edge, comparator maior=1 or menor=1: latch that flag into the result register, go DONE.
  - Else if index==0: set igual=1, go DONE.
  - Else: shift a_sh and b_sh left by 1 (zero fill), decrement index.
- DONE: done=1 for exactly this cycle, busy=0; unconditional return to IDLE next edge.
- Latency:
  - First difference at bit k (MSB = WIDTH-1): done rises WIDTH-k+1 edges after the start-sampling edge.
  - Equal operands: done rises WIDTH+1 edges after the start-sampling edge.
- Results:
  - Exactly one of maior/menor/igual is 1 from DONE until the next accepted start.
  - All three are 0 while busy.
- Boundary conditions:
  - start asserted in COMPARE or DONE: ignored, no queuing; requester must re-assert in IDLE.
  - start held high continuously: back-to-back operations, one IDLE cycle between done and the next busy.
  - Changes to a/b after acceptance have no effect.
  - rst_n low mid-operation: immediate return to reset values; no done pulse.
  - index never underflows; the COMPARE exit at index==0 is mandatory.

Optional Feature:
- Macro: COMPARADOR_SIGNED_EN.
- Defined: operands are two's complement. Only the first compared bit (sign bit, index==WIDTH-1) has its maior/menor interpretation swapped: a_msb=0, b_msb=1 gives maior=1. Remaining bits are unchanged. Latency is identical.
- Undefined: unsigned comparison as described above.

Test Plan (WIDTH=8):
- Reset: rst_n=0 with start=1 -> busy=0, done=0, maior=menor=igual=0; no transition until rst_n=1.
- Early exit: a=8'h80, b=8'h7F, start pulse -> done at edge 2 after start; maior=1, menor=0, igual=0; busy high exactly 1 cycle.
- Late difference: a=8'h10, b=8'h11 -> done at edge 9 after start (bit 0 decides); menor=1.
- Equal operands: a=b=8'hA5 -> done at edge 9 after start; igual=1; result held 5 idle cycles; a/b changed during busy has no effect.
- start during busy, then reset mid-operation: a=8'h01, b=8'h00, re-pulse start at cycle 3 -> ignored, single done with maior=1. Repeat and drop rst_n at cycle 4 -> no done, all outputs 0.
- COMPARADOR_SIGNED_EN defined: a=8'hFF (-1), b=8'h01 -> menor=1 at edge 2. Same stimulus without the macro -> maior=1.
